// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, widths and result record
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 5;

  // Codes 100-111 are unassigned; the decoder never emits them on purpose.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_ctrl_e;

  typedef struct packed {
    logic [ALU_XLEN-1:0]  result;
    logic                 zero;
    logic                 neg;
    logic                 carry;
    logic                 ovf;
    logic                 illegal;
    logic [ALU_TAG_W-1:0] tag;
  } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: (ctrl, a, b) -> result and flags
//
// Ports:
//   ctrl  in   3         alu_control code
//   a     in   ALU_XLEN  operand A
//   b     in   ALU_XLEN  operand B
//   res   out  alu_res_t result and flags; tag field is always 0 here
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0]          ctrl,
  input  logic [ALU_XLEN-1:0] a,
  input  logic [ALU_XLEN-1:0] b,
  output alu_res_t            res
);

  logic                is_sub;
  logic [ALU_XLEN-1:0] b_eff;
  logic [ALU_XLEN:0]   sum;
  logic                arith_ovf;

  // SUB is a + ~b + 1 so the shared adder gives carry = no-borrow.
  always_comb begin
    is_sub    = (ctrl == ALU_SUB);
    b_eff     = is_sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{ALU_XLEN{1'b0}}, is_sub};
    arith_ovf = (a[ALU_XLEN-1] == b_eff[ALU_XLEN-1]) &&
                (sum[ALU_XLEN-1] != a[ALU_XLEN-1]);
  end

  always_comb begin
    res = '0;
    case (ctrl)
      ALU_ADD, ALU_SUB: begin
        res.result = sum[ALU_XLEN-1:0];
        res.carry  = sum[ALU_XLEN];
        res.ovf    = arith_ovf;
      end
      ALU_AND: res.result = a & b;
      ALU_OR:  res.result = a | b;
      default: begin
        // Unassigned code: behave as ADD but mark it for the trap logic.
        res.result  = sum[ALU_XLEN-1:0];
        res.carry   = sum[ALU_XLEN];
        res.ovf     = arith_ovf;
        res.illegal = 1'b1;
      end
    endcase
    res.zero = (res.result == '0);
    res.neg  = res.result[ALU_XLEN-1];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: ALU plus registered output with 2-entry skid buffer
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake; in_ready depends on state only
//   in_ctrl, in_a, in_b, in_tag operation, operands and sideband tag
//   out_valid/out_ready         downstream handshake
//   out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal, out_tag
//                               registered result of the oldest pending op
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ctrl,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  state_e   state;
  logic     in_ready_q;
  logic     out_valid_q;
  alu_res_t core_res;
  alu_res_t in_res;
  alu_res_t m_reg;
  alu_res_t s_reg;
  logic     accept;

  alu_core u_core (
    .ctrl (in_ctrl),
    .a    (in_a),
    .b    (in_b),
    .res  (core_res)
  );

  always_comb begin
    in_res     = core_res;
    in_res.tag = in_tag;
  end

  assign accept = in_valid && in_ready_q;

  // in_ready is precomputed for the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_reg       <= '0;
      s_reg       <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_reg       <= in_res;
            state       <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            m_reg <= in_res;
          end else if (accept) begin
            s_reg      <= in_res;
            state      <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (out_ready) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            m_reg      <= s_reg;
            state      <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_result  = m_reg.result;
  assign out_zero    = m_reg.zero;
  assign out_neg     = m_reg.neg;
  assign out_carry   = m_reg.carry;
  assign out_ovf     = m_reg.ovf;
  assign out_illegal = m_reg.illegal;
  assign out_tag     = m_reg.tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_neg;
  logic        out_carry;
  logic        out_ovf;
  logic        out_illegal;
  logic [4:0]  out_tag;

  logic [41:0] obs;
  int          checks;
  int          errors;

  // {result, zero, neg, carry, ovf, illegal, tag}
  assign obs = {out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal, out_tag};

  alu_exec_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_carry   (out_carry),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one op for exactly one edge; caller guarantees in_ready=1.
  task automatic drive_one(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++;
    if (obs !== 42'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    drive_one(3'b000, 32'hFFFF_FFFF, 32'h1, 5'd3);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
    checks++;
    if (obs !== {32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3})
      begin errors++; $display("FAIL add_wrap got %h exp %h", obs, {32'h0, 5'b10100, 5'd3}); end
  endtask

  task automatic test_sub;
    drive_one(3'b001, 32'h8000_0000, 32'h1, 5'd4);
    checks++;
    if (obs !== {32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4})
      begin errors++; $display("FAIL sub_ovf got %h exp %h", obs, {32'h7FFF_FFFF, 5'b00110, 5'd4}); end
    drive_one(3'b001, 32'h5, 32'h7, 5'd5);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %b exp 1", out_valid); end
    checks++;
    if (obs !== {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5})
      begin errors++; $display("FAIL sub_borrow got %h exp %h", obs, {32'hFFFF_FFFE, 5'b01000, 5'd5}); end
  endtask

  task automatic test_logic;
    drive_one(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6);
    checks++;
    if (obs !== {32'hF000_F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6})
      begin errors++; $display("FAIL and got %h exp %h", obs, {32'hF000_F000, 5'b01000, 5'd6}); end
    drive_one(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
    checks++;
    if (obs !== {32'hFFF0_FFF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7})
      begin errors++; $display("FAIL or got %h exp %h", obs, {32'hFFF0_FFF0, 5'b01000, 5'd7}); end
  endtask

  task automatic test_illegal;
    drive_one(3'b110, 32'h2, 32'h3, 5'd8);
    checks++;
    if (obs !== {32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8})
      begin errors++; $display("FAIL illegal got %h exp %h", obs, {32'h5, 5'b00001, 5'd8}); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    fork
      begin : producer
        for (int i = 1; i <= 8; i++) begin
          int  n;
          logic r;
          n = 0;
          in_valid = 1'b1;
          in_ctrl  = 3'b000;
          in_a     = 32'(i);
          in_b     = 32'(i * 16);
          in_tag   = 5'(i);
          do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
          end while (!r && n < 50);
          if (!r) begin
            errors++;
            $display("FAIL b2b_accept_timeout tag %0d got no accept exp accept", i);
          end
        end
        in_valid = 1'b0;
      end
      begin : consumer
        logic [41:0] snap;
        int          exp_tag;
        int          k;
        exp_tag = 1;
        @(posedge clk);
        @(negedge clk);
        snap = obs;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b1)
          begin errors++; $display("FAIL b2b_first got v=%b tag=%0d rdy=%b exp v=1 tag=1 rdy=1", out_valid, out_tag, in_ready); end
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b exp 0", in_ready); end
          checks++;
          if (obs !== snap || out_valid !== 1'b1)
            begin errors++; $display("FAIL b2b_stall_stable got %h exp %h", obs, snap); end
        end
        k = 0;
        while (exp_tag <= 8 && k < 60) begin
          out_ready = (k % 3 != 2);
          if (out_valid && out_ready) begin
            checks++;
            if (out_tag !== 5'(exp_tag))
              begin errors++; $display("FAIL b2b_order got %0d exp %0d", out_tag, exp_tag); end
            checks++;
            if (out_result !== 32'(exp_tag * 17))
              begin errors++; $display("FAIL b2b_result got %h exp %h", out_result, 32'(exp_tag * 17)); end
            exp_tag++;
          end
          k++;
          if (exp_tag <= 8) @(negedge clk);
        end
        checks++;
        if (exp_tag !== 9) begin errors++; $display("FAIL b2b_count got %0d exp 8", exp_tag - 1); end
        out_ready = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b000;
    in_a      = 32'h1;
    in_b      = 32'h1;
    in_tag    = 5'd9;
    @(posedge clk);
    #1;
    in_tag = 5'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin errors++; $display("FAIL rst_pre_full got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got %b exp 1", in_ready); end
    checks++;
    if (obs !== 42'h0) begin errors++; $display("FAIL rst_async_outputs got %h exp 0", obs); end
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale got %b exp 0", out_valid); end
    drive_one(3'b011, 32'h1, 32'h2, 5'd7);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid got %b exp 1", out_valid); end
    checks++;
    if (obs !== {32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7})
      begin errors++; $display("FAIL rst_first_op got %h exp %h", obs, {32'h3, 5'b00000, 5'd7}); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 3'b000;
    in_a      = 32'h0;
    in_b      = 32'h0;
    in_tag    = 5'd0;
    out_ready = 1'b1;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
